// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Function : Data-memory bus responder with a word RAM and configurable wait states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_cyc_i,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic [DATA_W-1:0] data_dat_i,
    output logic [DATA_W-1:0] data_dat_o,
    output logic              data_ack_o,
    output logic              data_err_o,
    output logic              busy_o
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;

    localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_wait  = 4'(WAIT_CYCLES);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [3:0]         r_cnt;
    logic [ADDR_W-1:0]  r_adr;
    logic               r_we;
    logic [DATA_W-1:0]  r_dat;
    logic               r_oor;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_req;
    logic [ADDR_W-1:0]  w_adr;
    logic               w_we;
    logic [DATA_W-1:0]  w_dat;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_commit;

    assign w_req = data_cyc_i & data_stb_i;

    // With zero wait states the commit edge is the request edge, so use live inputs in IDLE.
    assign w_adr      = (r_state == c_st_idle) ? data_adr_i : r_adr;
    assign w_we       = (r_state == c_st_idle) ? data_we_i  : r_we;
    assign w_dat      = (r_state == c_st_idle) ? data_dat_i : r_dat;
    assign w_in_range = ({1'b0, w_adr} < c_depth);
    assign w_idx      = w_adr[c_idx_w-1:0];
    assign w_commit   = rst && (r_state != c_st_ack) && (w_next == c_st_ack);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES == 0) ? c_st_ack : c_st_wait;
                end
            end
            c_st_wait: begin
                if (!data_cyc_i) begin
                    w_next = c_st_idle;
                end else if (r_cnt <= 4'd1) begin
                    w_next = c_st_ack;
                end
            end
            c_st_ack: w_next = c_st_idle;
            default:  w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_st_idle) && w_req) begin
                r_adr <= data_adr_i;
                r_we  <= data_we_i;
                r_dat <= data_dat_i;
                r_cnt <= c_wait;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_oor <= !w_in_range;
                if (!w_we) begin
                    r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_we && w_in_range) begin
            r_mem[w_idx] <= w_dat;
        end
    end

    always_comb begin
        data_ack_o = (r_state == c_st_ack);
        data_err_o = (r_state == c_st_ack) && r_oor;
        busy_o     = (r_state != c_st_idle);
        data_dat_o = r_rdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Function : Scoreboard bench for data_mem_responder in three configurations.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    typedef struct {
        int         lat;
        logic [7:0] dat;
        logic       err;
        logic       rd;
    } sb_t;

    logic       clk;
    logic       rst;
    logic       cyc  [3];
    logic       stb  [3];
    logic       we   [3];
    logic [7:0] adr  [3];
    logic [7:0] dati [3];
    logic [7:0] dato [3];
    logic       ack  [3];
    logic       err  [3];
    logic       busy [3];

    logic [7:0] mdl [3][256];
    sb_t        sbq [$];
    int         n_total;
    int         n_bad;

    // inst 0: 1 wait / 256 words, inst 1: 0 waits / 128 words, inst 2: 3 waits / 256 words
    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[0]), .data_stb_i(stb[0]), .data_we_i(we[0]),
        .data_adr_i(adr[0]), .data_dat_i(dati[0]), .data_dat_o(dato[0]),
        .data_ack_o(ack[0]), .data_err_o(err[0]), .busy_o(busy[0]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[1]), .data_stb_i(stb[1]), .data_we_i(we[1]),
        .data_adr_i(adr[1]), .data_dat_i(dati[1]), .data_dat_o(dato[1]),
        .data_ack_o(ack[1]), .data_err_o(err[1]), .busy_o(busy[1]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[2]), .data_stb_i(stb[2]), .data_we_i(we[2]),
        .data_adr_i(adr[2]), .data_dat_i(dati[2]), .data_dat_o(dato[2]),
        .data_ack_o(ack[2]), .data_err_o(err[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int dp(input int d);
        return (d == 1) ? 128 : 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] v);
        sb_t it;
        sb_t ex;
        int  k;
        bit  got;
        it.lat = wc(d);
        it.err = (int'(a) >= dp(d));
        it.rd  = !w;
        it.dat = (!w && !it.err) ? mdl[d][a] : 8'h00;
        if (w && !it.err) mdl[d][a] = v;
        sbq.push_back(it);

        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = v;
        @(negedge clk);
        check("idle_busy", busy[d], 1'b0);
        @(posedge clk); #1;
        stb[d] = 1'b0; adr[d] = ~a; dati[d] = ~v; we[d] = ~w;
        k = 0;
        got = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            check("busy", busy[d], 1'b1);
            if (ack[d]) begin
                got = 1;
                ex = sbq.pop_front();
                check("latency", k, ex.lat);
                check("err", err[d], ex.err);
                if (ex.rd) check("rdata", dato[d], ex.dat);
            end
            k++;
        end
        if (!got) begin
            ex = sbq.pop_front();
            check("ack_timeout", 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        cyc[d] = 1'b0;
        @(negedge clk);
        check("ack_pulse", ack[d], 1'b0);
        check("busy_after", busy[d], 1'b0);
    endtask

    initial begin
        int k1;
        int k2;
        int nack;
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; dati[i] = 0;
        end
        #23;
        for (int i = 0; i < 3; i++) begin
            check("rst_ack", ack[i], 1'b0);
            check("rst_err", err[i], 1'b0);
            check("rst_busy", busy[i], 1'b0);
            check("rst_dat", dato[i], 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;

        // write then read back-to-back, one wait state
        xfer(0, 1'b1, 8'h10, 8'h5A);
        xfer(0, 1'b0, 8'h10, 8'h00);

        // zero wait states, 128 words: out-of-range access raises err
        xfer(1, 1'b1, 8'h00, 8'hC3);
        xfer(1, 1'b1, 8'h80, 8'hFF);
        xfer(1, 1'b0, 8'h80, 8'h00);
        xfer(1, 1'b0, 8'h00, 8'h00);
        xfer(1, 1'b1, 8'h7F, 8'h9E);
        xfer(1, 1'b0, 8'h7F, 8'h00);

        // three wait states, then an aborted write
        xfer(2, 1'b1, 8'h05, 8'h12);
        xfer(2, 1'b0, 8'h05, 8'h00);
        @(posedge clk); #1;
        cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 8'h05; dati[2] = 8'h33;
        @(posedge clk); #1;
        stb[2] = 0;
        @(posedge clk); #1;
        cyc[2] = 0;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[2]) nack++;
        end
        check("abort_ack", nack, 0);
        check("abort_idle", busy[2], 1'b0);
        xfer(2, 1'b0, 8'h05, 8'h00);

        // strobe held one cycle past ack produces a second transfer
        @(posedge clk); #1;
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 8'h10;
        k1 = -1; k2 = -1; nack = 0;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack[0]) begin
                nack++;
                check("hold_rdata", dato[0], 8'h5A);
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
            if (k1 >= 0 && k == k1 + 1) begin
                @(posedge clk); #1;
                stb[0] = 0;
            end
        end
        cyc[0] = 0;
        check("hold_acks", nack, 2);
        check("hold_first", k1, 1);
        check("hold_gap", k2 - k1, 3);

        // reset during the wait state of a write
        xfer(0, 1'b1, 8'h20, 8'h11);
        xfer(0, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 8'h20; dati[0] = 8'h77;
        @(posedge clk); #1;
        stb[0] = 0;
        #2;
        check("pre_rst_busy", busy[0], 1'b1);
        rst = 1'b0;
        #1;
        check("arst_busy", busy[0], 1'b0);
        check("arst_ack", ack[0], 1'b0);
        check("arst_err", err[0], 1'b0);
        check("arst_dat", dato[0], 8'h00);
        cyc[0] = 0;
        @(negedge clk);
        rst = 1'b1;
        xfer(0, 1'b0, 8'h20, 8'h00);

        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
